// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared types and constants for the sequential divider.
// Revision : 1.0
// ============================================================================
package div_pkg;

    localparam int DIV_WIDTH = 16;

    function automatic int div_cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int DIV_CNT_W = div_cnt_width(DIV_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_if
// Purpose  : Request/response bundle between a divider client and the divider.
// Revision : 1.0
// ============================================================================
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] remainder;
    logic             Busy;
    logic             Ready;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  result, remainder, Busy, Ready, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output result, remainder, Busy, Ready, div_zero
    );

endinterface
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One restoring shift-subtract step on a WIDTH+1-bit partial remainder.
// Revision : 1.0
// ============================================================================
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  wire logic [WIDTH-1:0] rem_in,
    input  wire logic             bit_in,
    input  wire logic [WIDTH-1:0] divisor,
    output logic      [WIDTH-1:0] rem_out,
    output logic                  q_bit
);

    logic [WIDTH:0] w_trial;
    logic [WIDTH:0] w_diff;

    assign w_trial = {rem_in, bit_in};
    assign w_diff  = w_trial - {1'b0, divisor};

    // rem_in < divisor keeps a successful subtraction below 2^WIDTH, so the
    // top bit of the difference is exactly the borrow.
    assign q_bit   = ~w_diff[WIDTH];
    assign rem_out = q_bit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Unsigned restoring divider, one quotient bit per cycle, MSB first.
//            Define DIV_ROUND_EN to add a round-to-nearest cycle before DONE.
// Revision : 1.0
// ============================================================================
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  wire logic      clk,
    input  wire logic      rst,
    seq_divider_if.slave   bus
);

    localparam int CNT_W = div_cnt_width(WIDTH);

    div_state_t       r_state;
    div_state_t       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_zero;

    logic [CNT_W-1:0] w_bit_idx;
    logic             w_last;
    logic [WIDTH-1:0] w_rem;
    logic             w_qbit;
    logic [WIDTH-1:0] w_quot_step;
    logic             w_dz;
    logic             w_load;
    logic [WIDTH-1:0] w_fin_quot;
    logic [WIDTH-1:0] w_fin_rem;

    assign w_bit_idx   = CNT_W'(WIDTH - 1) - r_cnt;
    assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_quot_step = {r_quot[WIDTH-2:0], w_qbit};
    assign w_dz        = (r_divisor == '0);

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (r_rem),
        .bit_in  (r_dividend[w_bit_idx]),
        .divisor (r_divisor),
        .rem_out (w_rem),
        .q_bit   (w_qbit)
    );

`ifdef DIV_ROUND_EN
    logic             w_round_up;
    logic [WIDTH-1:0] w_quot_rnd;

    // Compare 2*remainder against the divisor without losing the carry bit.
    assign w_round_up = ({r_rem, 1'b0} >= {1'b0, r_divisor});
    assign w_quot_rnd = (!w_dz && w_round_up && (r_quot != '1)) ? r_quot + 1'b1 : r_quot;
    assign w_load     = (r_state == ST_ROUND);
    assign w_fin_quot = w_quot_rnd;
    assign w_fin_rem  = r_rem;
`else
    assign w_load     = (r_state == ST_CALC) && w_last;
    assign w_fin_quot = w_quot_step;
    assign w_fin_rem  = w_rem;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next = ST_CALC;
                end
            end
            ST_CALC: begin
                if (w_last) begin
`ifdef DIV_ROUND_EN
                    w_next = ST_ROUND;
`else
                    w_next = ST_DONE;
`endif
                end
            end
            ST_ROUND: w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.Busy  = (r_state == ST_CALC) || (r_state == ST_ROUND);
        bus.Ready = (r_state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
        end else if ((r_state == ST_IDLE) && bus.start) begin
            r_cnt      <= '0;
            r_dividend <= bus.dividend;
            r_divisor  <= bus.divisor;
            r_quot     <= '0;
            r_rem      <= '0;
        end else if (r_state == ST_CALC) begin
            r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
            r_quot <= w_quot_step;
            r_rem  <= w_rem;
        end
    end

    // Result registers update only on entry to DONE and hold until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else if (w_load) begin
            r_result    <= w_dz ? '1 : w_fin_quot;
            r_remainder <= w_dz ? r_dividend : w_fin_rem;
            r_div_zero  <= w_dz;
        end
    end

    assign bus.result    = r_result;
    assign bus.remainder = r_remainder;
    assign bus.div_zero  = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Purpose  : Self-checking bench for seq_divider against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_seq_divider;

    localparam int W = 16;
`ifdef DIV_ROUND_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic dz);
        int unsigned ai = a;
        int unsigned bi = b;
        int unsigned qi;
        int unsigned ri;
        if (bi == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else begin
            qi = ai / bi;
            ri = ai % bi;
`ifdef DIV_ROUND_EN
            if ((2 * ri >= bi) && (qi < (1 << W) - 1)) qi = qi + 1;
`endif
            q  = W'(qi);
            r  = W'(ri);
            dz = 1'b0;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one division and checks Busy/Ready every cycle through the
    // first IDLE cycle after Ready. Operands are scrambled after acceptance;
    // with hold=0 start is also toggled randomly while the divider is not idle.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        ref_div(a, b, q, r, dz);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        for (int i = 1; i <= LAT + 1; i++) begin
            step();
            check("busy",  bus.Busy,  (i < LAT));
            check("ready", bus.Ready, (i == LAT));
            if (i >= LAT) begin
                check("result",    bus.result,    q);
                check("remainder", bus.remainder, r);
                check("div_zero",  bus.div_zero,  dz);
            end
            bus.dividend = W'($urandom);
            bus.divisor  = W'($urandom);
            if (!hold) bus.start = (i <= LAT) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) step();
        check("rst_busy",      bus.Busy,      0);
        check("rst_ready",     bus.Ready,     0);
        check("rst_result",    bus.result,    0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_div_zero",  bus.div_zero,  0);
        rst = 1'b0;
        step();
        check("idle_busy", bus.Busy, 0);

        run_div(16'd1000,  16'd3,    1'b0);
        run_div(16'd1000,  16'd6,    1'b0);
        run_div(16'h1234,  16'd0,    1'b0);
        run_div(16'd50,    16'd5,    1'b0);
        run_div(16'd0,     16'd7,    1'b0);
        run_div(16'hFFFF,  16'hFFFF, 1'b0);
        run_div(16'd5,     16'd7,    1'b0);
        run_div(16'hFFFF,  16'd2,    1'b0);
        run_div(16'h8000,  16'h8001, 1'b0);

        // Abort an operation with reset while start is also asserted.
        bus.dividend = 16'd1000;
        bus.divisor  = 16'd3;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            check("pre_abort_busy", bus.Busy, 1);
        end
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.dividend = 16'd77;
        bus.divisor  = 16'd7;
        step();
        check("abort_busy",      bus.Busy,      0);
        check("abort_ready",     bus.Ready,     0);
        check("abort_result",    bus.result,    0);
        check("abort_remainder", bus.remainder, 0);
        check("abort_div_zero",  bus.div_zero,  0);
        rst = 1'b0;
        run_div(16'hFFFF, 16'd1, 1'b0);

        // start held high: each operation is accepted on the first IDLE cycle.
        for (int k = 0; k < 4; k++) begin
            a = W'($urandom);
            b = W'($urandom_range(1, 300));
            run_div(a, b, 1'b1);
        end
        bus.start = 1'b0;
        step();
        check("b2b_end_busy", bus.Busy, 0);

        for (int k = 0; k < 40; k++) begin
            a = W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 15));
                default: b = W'($urandom);
            endcase
            run_div(a, b, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                step();
                check("gap_busy", bus.Busy, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
